// File: rtl/instr_decode_exec.sv
// ----------------------------------------------------------------------------
// instr_decode_exec
//
// Instruction register, decoder and execute stage of the fetch-execute loop.
// The word the ROM returns for the current program counter is latched into
// IR each cycle. During the following cycle it executes against a 4 x 8-bit
// register file and the Z/C flags. Taken jumps and HALT go back to the
// program counter through JMP / JMP_OFFSET. The counter adds ADDR + 1 + d,
// where d = {0, +1, -2, -1} for offset codes 00/01/10/11.
//
// Instruction set:
//   00 rd rs f   ALU: f=00 ADD, 01 SUB, 10 AND, 11 OR. Writes Z and C.
//   01 rd imm4   LI:  rd = zero-extended imm4. Flags are unchanged.
//   10 cc xx off JUMP: cc=00 always, 01 Z, 10 !Z, 11 C.
//   11 111111    HALT. Every other 11xxxxxx code is a NOP.
//
// Ports:
//   CLK         in   rising-edge clock
//   RST         in   asynchronous active-high reset
//   ADDR        in   current program counter; it is captured into IR_ADDR
//   IMEM_DATA   in   instruction word at ADDR from the combinational ROM
//   JMP         out  jump request to the program counter (combinational)
//   JMP_OFFSET  out  offset code that goes with JMP (combinational)
//   RD_SEL      in   register-file observation select
//   RD_DATA     out  contents of the register picked by RD_SEL (combinational)
//   FLAG_Z      out  registered zero flag
//   FLAG_C      out  registered carry/borrow flag
//   HALTED      out  sticky halt indicator; only RST clears it
//   IR_ADDR     out  address of the instruction currently held in IR
// ----------------------------------------------------------------------------
module instr_decode_exec (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] ADDR,
    input  logic [7:0] IMEM_DATA,
    output logic       JMP,
    output logic [1:0] JMP_OFFSET,
    input  logic [1:0] RD_SEL,
    output logic [7:0] RD_DATA,
    output logic       FLAG_Z,
    output logic       FLAG_C,
    output logic       HALTED,
    output logic [7:0] IR_ADDR
);

    // Opcode classes, taken from IR[7:6]
    localparam logic [1:0] OP_ALU  = 2'b00;
    localparam logic [1:0] OP_LI   = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b10;
    localparam logic [1:0] OP_MISC = 2'b11;

    // Low six bits of the one MISC code that halts
    localparam logic [5:0] MISC_HALT = 6'h3F;

    // Offset codes that the counter turns into "go back to A" / "hold"
    localparam logic [1:0] OFF_BACK_TO_SELF = 2'b10;
    localparam logic [1:0] OFF_HOLD         = 2'b11;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // ALU result. Bit 8 carries the new C flag: the carry out for ADD,
    // the borrow for SUB, and zero for the logical ops.
    function automatic logic [8:0] alu_compute(
        input logic [1:0] func,
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] result;
        case (func)
            2'b00:   result = {1'b0, a} + {1'b0, b};
            2'b01:   result = {(a < b), a - b};
            2'b10:   result = {1'b0, a & b};
            2'b11:   result = {1'b0, a | b};
            default: result = 9'h000;
        endcase
        return result;
    endfunction

    // Jump condition, tested against the flags as they are currently registered
    function automatic logic cond_met(
        input logic [1:0] cond,
        input logic       z,
        input logic       c
    );
        logic met;
        case (cond)
            2'b00:   met = 1'b1;
            2'b01:   met = z;
            2'b10:   met = ~z;
            2'b11:   met = c;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0] ir_r;
    logic [7:0] ir_addr_r;
    logic       ir_v_r;
    logic [7:0] reg_file_r [0:3];
    logic       flag_z_r;
    logic       flag_c_r;
    state_e     state_r;
    state_e     state_next_s;

    // ------------------------------------------------------------------
    // Decode signals
    // ------------------------------------------------------------------
    logic [1:0] opcode_s;
    logic [1:0] rd_idx_s;
    logic [1:0] rs_idx_s;
    logic [1:0] func_s;
    logic [1:0] cond_s;
    logic [1:0] off_s;
    logic [3:0] imm_s;

    logic       exec_valid_s;
    logic       is_alu_s;
    logic       is_li_s;
    logic       is_jump_s;
    logic       is_halt_s;
    logic       jump_taken_s;

    logic [8:0] alu_out_s;
    logic       reg_we_s;
    logic [7:0] reg_wdata_s;
    logic       flag_we_s;
    logic       flag_z_next_s;
    logic       flag_c_next_s;

    logic       jmp_s;
    logic [1:0] jmp_offset_s;

    assign opcode_s = ir_r[7:6];
    assign rd_idx_s = ir_r[5:4];
    assign rs_idx_s = ir_r[3:2];
    assign func_s   = ir_r[1:0];
    assign cond_s   = ir_r[5:4];
    assign off_s    = ir_r[1:0];
    assign imm_s    = ir_r[3:0];

    // An instruction only takes effect when IR is valid and the machine is running
    assign exec_valid_s = ir_v_r && (state_r == ST_RUN);

    // Instruction class decode, gated by validity
    always_comb begin
        is_alu_s     = 1'b0;
        is_li_s      = 1'b0;
        is_jump_s    = 1'b0;
        is_halt_s    = 1'b0;
        jump_taken_s = 1'b0;
        if (exec_valid_s) begin
            case (opcode_s)
                OP_ALU:  is_alu_s  = 1'b1;
                OP_LI:   is_li_s   = 1'b1;
                OP_JUMP: is_jump_s = 1'b1;
                OP_MISC: is_halt_s = (ir_r[5:0] == MISC_HALT);
                default: is_alu_s  = 1'b0;
            endcase
            jump_taken_s = is_jump_s && cond_met(cond_s, flag_z_r, flag_c_r);
        end else begin
            jump_taken_s = 1'b0;
        end
    end

    // Register-file write data and flag updates for the executing instruction
    always_comb begin
        alu_out_s     = alu_compute(func_s, reg_file_r[rd_idx_s], reg_file_r[rs_idx_s]);
        reg_we_s      = 1'b0;
        reg_wdata_s   = 8'h00;
        flag_we_s     = 1'b0;
        flag_z_next_s = flag_z_r;
        flag_c_next_s = flag_c_r;
        if (is_alu_s) begin
            reg_we_s      = 1'b1;
            reg_wdata_s   = alu_out_s[7:0];
            flag_we_s     = 1'b1;
            flag_z_next_s = (alu_out_s[7:0] == 8'h00);
            flag_c_next_s = alu_out_s[8];
        end else if (is_li_s) begin
            reg_we_s    = 1'b1;
            reg_wdata_s = {4'h0, imm_s};
        end else begin
            reg_we_s  = 1'b0;
            flag_we_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Run/halt state machine
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: a valid HALT is the only way in, and reset is the only way out
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (is_halt_s) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // Jump request to the counter. While halted, the counter holds. A HALT
    // sends it back to the HALT address. A taken jump passes its offset on.
    always_comb begin
        jmp_s        = 1'b0;
        jmp_offset_s = 2'b00;
        if (state_r == ST_HALTED) begin
            jmp_s        = 1'b1;
            jmp_offset_s = OFF_HOLD;
        end else if (is_halt_s) begin
            jmp_s        = 1'b1;
            jmp_offset_s = OFF_BACK_TO_SELF;
        end else if (jump_taken_s) begin
            jmp_s        = 1'b1;
            jmp_offset_s = off_s;
        end else begin
            jmp_s        = 1'b0;
            jmp_offset_s = 2'b00;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // IR stage. A redirect or a halt squashes the word captured at the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ir_r      <= 8'h00;
            ir_addr_r <= 8'h00;
            ir_v_r    <= 1'b0;
        end else begin
            ir_r      <= IMEM_DATA;
            ir_addr_r <= ADDR;
            ir_v_r    <= !jmp_s && (state_r == ST_RUN);
        end
    end

    // Register file write port
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                reg_file_r[i] <= 8'h00;
            end
        end else if (reg_we_s) begin
            reg_file_r[rd_idx_s] <= reg_wdata_s;
        end
    end

    // Z/C flags. ALU ops are the only instructions that update them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
        end else if (flag_we_s) begin
            flag_z_r <= flag_z_next_s;
            flag_c_r <= flag_c_next_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign JMP        = jmp_s;
    assign JMP_OFFSET = jmp_offset_s;
    assign RD_DATA    = reg_file_r[RD_SEL];
    assign FLAG_Z     = flag_z_r;
    assign FLAG_C     = flag_c_r;
    assign HALTED     = (state_r == ST_HALTED);
    assign IR_ADDR    = ir_addr_r;

endmodule

// File: tb/tb_instr_decode_exec.sv
// ----------------------------------------------------------------------------
// Testbench for instr_decode_exec. It closes the fetch loop with a program
// counter and a ROM, runs the directed programs, and then runs random
// programs. Each random run is checked against an instruction-level
// interpreter that charges one cycle per instruction plus one bubble cycle
// per taken jump.
// ----------------------------------------------------------------------------
module tb_instr_decode_exec;

    logic       clk;
    logic       rst;
    logic [7:0] pc;
    logic [7:0] imem_data;
    logic       jmp;
    logic [1:0] jmp_offset;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic       flag_z;
    logic       flag_c;
    logic       halted;
    logic [7:0] ir_addr;

    logic [7:0] rom [0:255];
    logic [7:0] prog_q [$];

    int n_checks = 0;
    int n_errors = 0;

    // Interpreter results
    logic [7:0] m_reg [4];
    logic       m_z;
    logic       m_c;
    logic       m_halt;
    logic [7:0] m_hpc;

    instr_decode_exec dut (
        .CLK        (clk),
        .RST        (rst),
        .ADDR       (pc),
        .IMEM_DATA  (imem_data),
        .JMP        (jmp),
        .JMP_OFFSET (jmp_offset),
        .RD_SEL     (rd_sel),
        .RD_DATA    (rd_data),
        .FLAG_Z     (flag_z),
        .FLAG_C     (flag_c),
        .HALTED     (halted),
        .IR_ADDR    (ir_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_data = rom[pc];

    function automatic logic [7:0] off_delta(input logic [1:0] o);
        case (o)
            2'b00:   return 8'h00;
            2'b01:   return 8'h01;
            2'b10:   return 8'hFE;
            default: return 8'hFF;
        endcase
    endfunction

    // Program counter: load ADDR+1+d on a jump request, otherwise increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= 8'h00;
        else if (jmp) pc <= pc + 8'd1 + off_delta(jmp_offset);
        else pc <= pc + 8'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [1:0] i, output logic [7:0] v);
        rd_sel = i;
        #1;
        v = rd_data;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] i, input logic [7:0] exp);
        logic [7:0] v;
        read_reg(i, v);
        check_eq(tag, {24'h0, v}, {24'h0, exp});
    endtask

    task automatic load_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
        for (int i = 0; i < prog_q.size(); i++) rom[i] = prog_q[i];
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        #1;
    endtask

    // Let go of reset half a cycle before the next rising edge
    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // All outputs must show their reset values while RST is held
    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_jmp"}, jmp, 1'b0);
        check_eq({tag, "_off"}, jmp_offset, 2'b00);
        check_eq({tag, "_halted"}, halted, 1'b0);
        check_eq({tag, "_z"}, flag_z, 1'b0);
        check_eq({tag, "_c"}, flag_c, 1'b0);
        check_eq({tag, "_iraddr"}, ir_addr, 8'h00);
        for (int i = 0; i < 4; i++) check_reg($sformatf("%s_r%0d", tag, i), 2'(i), 8'h00);
    endtask

    // Instruction-level interpreter. It runs for 'budget' execute cycles.
    task automatic ref_run(input int budget);
        int         t;
        int         s;
        logic [7:0] pcm, ins, a, b, res;
        logic       taken;
        pcm = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0; m_hpc = 8'h00;
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        t = budget;
        while (t > 0 && !m_halt) begin
            ins = rom[pcm];
            t--;
            if (ins[7:6] == 2'b00) begin
                a = m_reg[ins[5:4]];
                b = m_reg[ins[3:2]];
                case (ins[1:0])
                    2'b00: begin s = int'(a) + int'(b); res = s[7:0]; m_c = (s > 255); end
                    2'b01: begin s = int'(a) - int'(b); res = s[7:0]; m_c = (s < 0); end
                    2'b10: begin res = a & b; m_c = 1'b0; end
                    default: begin res = a | b; m_c = 1'b0; end
                endcase
                m_z = (res == 8'h00);
                m_reg[ins[5:4]] = res;
                pcm = pcm + 8'd1;
            end else if (ins[7:6] == 2'b01) begin
                m_reg[ins[5:4]] = {4'h0, ins[3:0]};
                pcm = pcm + 8'd1;
            end else if (ins[7:6] == 2'b10) begin
                case (ins[5:4])
                    2'b00: taken = 1'b1;
                    2'b01: taken = m_z;
                    2'b10: taken = !m_z;
                    default: taken = m_c;
                endcase
                if (taken) begin
                    case (ins[1:0])
                        2'b00: pcm = pcm + 8'd2;
                        2'b01: pcm = pcm + 8'd3;
                        2'b10: pcm = pcm;
                        default: pcm = pcm + 8'd1;
                    endcase
                    t--;
                end else begin
                    pcm = pcm + 8'd1;
                end
            end else begin
                if (ins == 8'hFF) begin
                    m_halt = 1'b1;
                    m_hpc  = pcm;
                end else begin
                    pcm = pcm + 8'd1;
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int skip_seq[10]  = '{0, 1, 2, 3, 4, 5, 6, 5, 5, 5};
        int flush_seq[7]  = '{0, 1, 3, 4, 5, 4, 4};
        logic [7:0] add_seq[5] = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0};
        int k;

        rst    = 1'b1;
        rd_sel = 2'b00;
        prog_q = '{8'h45, 8'h55, 8'h05, 8'h90, 8'h61, 8'hFF};
        load_rom();
        #2;
        check_reset_outputs("por");

        // Conditional skip, then hold while halted
        release_reset();
        check_eq("skip_addr0", pc, 8'h00);
        for (int e = 1; e < 10; e++) begin
            step(1);
            check_eq($sformatf("skip_addr%0d", e), pc, skip_seq[e]);
            if (e == 6) begin
                check_eq("skip_iraddr", ir_addr, 8'h05);
                check_eq("skip_not_halted", halted, 1'b0);
            end
            if (e == 7) check_eq("skip_halted", halted, 1'b1);
        end
        check_reg("skip_r0", 2'd0, 8'h00);
        check_reg("skip_r2", 2'd2, 8'h00);
        check_eq("skip_z", flag_z, 1'b1);
        check_eq("skip_c", flag_c, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_eq($sformatf("hold_jmp%0d", i), jmp, 1'b1);
            check_eq($sformatf("hold_off%0d", i), jmp_offset, 2'b11);
            check_eq($sformatf("hold_addr%0d", i), pc, 8'h05);
        end
        check_reg("hold_r0", 2'd0, 8'h00);
        check_reg("hold_r1", 2'd1, 8'h05);
        check_reg("hold_r2", 2'd2, 8'h00);

        // Asynchronous reset while halted
        assert_reset();
        check_reset_outputs("rst_halt");

        // Reset in the middle of a jump, then the flush program
        prog_q = '{8'h81, 8'h5F, 8'h6F, 8'h7F, 8'hFF};
        load_rom();
        release_reset();
        check_eq("first_cycle_jmp", jmp, 1'b0);
        step(1);
        check_eq("instr0_jmp", jmp, 1'b1);
        check_eq("instr0_off", jmp_offset, 2'b01);
        check_eq("instr0_iraddr", ir_addr, 8'h00);
        assert_reset();
        check_reset_outputs("rst_jump");
        release_reset();
        check_eq("flush_addr0", pc, 8'h00);
        for (int e = 1; e < 7; e++) begin
            step(1);
            check_eq($sformatf("flush_addr%0d", e), pc, flush_seq[e]);
        end
        check_reg("flush_r1", 2'd1, 8'h00);
        check_reg("flush_r2", 2'd2, 8'h00);
        check_reg("flush_r3", 2'd3, 8'h0F);
        check_eq("flush_halted", halted, 1'b1);

        // Carry chain, followed by a taken JC
        assert_reset();
        prog_q = '{8'h4F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB0, 8'h5F, 8'hFF};
        load_rom();
        release_reset();
        step(2);
        check_reg("carry_li", 2'd0, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_reg($sformatf("carry_r0_%0d", i), 2'd0, add_seq[i]);
            check_eq($sformatf("carry_c_%0d", i), flag_c, (i == 4) ? 1'b1 : 1'b0);
        end
        check_eq("carry_z", flag_z, 1'b0);
        check_eq("jc_jmp", jmp, 1'b1);
        check_eq("jc_off", jmp_offset, 2'b00);
        step(1);
        check_eq("jc_target", pc, 8'h08);
        step(2);
        check_eq("carry_halted", halted, 1'b1);
        check_reg("carry_r1", 2'd1, 8'h00);

        // Borrow, followed by a taken JNZ
        assert_reset();
        prog_q = '{8'h42, 8'h55, 8'h05, 8'hA0, 8'h6F, 8'hFF};
        load_rom();
        release_reset();
        step(4);
        check_reg("borrow_r0", 2'd0, 8'hFD);
        check_eq("borrow_c", flag_c, 1'b1);
        check_eq("borrow_z", flag_z, 1'b0);
        check_eq("jnz_jmp", jmp, 1'b1);
        step(1);
        check_eq("jnz_target", pc, 8'h05);
        step(3);
        check_eq("borrow_halted", halted, 1'b1);
        check_eq("borrow_haltaddr", pc, 8'h05);
        check_reg("borrow_r2", 2'd2, 8'h00);

        // Random programs checked against the interpreter
        for (int trial = 0; trial < 30; trial++) begin
            assert_reset();
            for (int i = 0; i < 256; i++) begin
                rom[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            end
            k = $urandom_range(2, 150);
            release_reset();
            step(k);
            ref_run(k - 1);
            for (int i = 0; i < 4; i++) check_reg($sformatf("rnd%0d_r%0d", trial, i), 2'(i), m_reg[i]);
            check_eq($sformatf("rnd%0d_z", trial), flag_z, m_z);
            check_eq($sformatf("rnd%0d_c", trial), flag_c, m_c);
            check_eq($sformatf("rnd%0d_halted", trial), halted, m_halt);
            if (m_halt) check_eq($sformatf("rnd%0d_haltaddr", trial), pc, m_hpc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_exec.md
# instr_decode_exec

Instruction register, decoder and execute stage that sits directly downstream of the program counter. Latches the instruction word addressed by `ADDR`, executes it against a 4×8-bit register file and Z/C flags, and resolves jumps and halt back into the counter's `JMP`/`JMP_OFFSET` inputs. Together with the counter and an asynchronous instruction ROM, it forms the complete fetch–execute loop.

## Interface
- No parameters; all widths fixed at 8-bit data and 8-bit address.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `ADDR`  in  8  current program counter value, used only for debug output.
- `IMEM_DATA`  in  8  instruction word at `ADDR` from the combinational ROM.
- `JMP`  out  1  jump request to the counter. When high at an edge, the counter loads `ADDR+1+d`, with d = {0, +1, −2, −1} for offset 00/01/10/11.
- `JMP_OFFSET`  out  2  offset code accompanying `JMP`.
- `RD_SEL`  in  2  register-file observation select.
- `RD_DATA`  out  8  combinational contents of the register selected by `RD_SEL`.
- `FLAG_Z`, `FLAG_C`  out  1 each  registered flags.
- `HALTED`  out  1  sticky halt indicator.
- `IR_ADDR`  out  8  address of the instruction held in IR.

## Operation
- **IR stage:** each edge, `IR <= IMEM_DATA`, `IR_ADDR <= ADDR`, `IR_V <= !jump_taken && !HALTED`. The instruction in IR executes during the cycle it is held. Results and flags commit at the edge that ends that cycle.
- **ALU op (`00 rd[5:4] rs[3:2] f[1:0]`):**
  - f=00: ADD, rd = rd + rs; C = carry out of bit 7.
  - f=01: SUB, rd = rd − rs; C = 1 iff rd < rs unsigned (borrow).
  - f=10: AND; C cleared.
  - f=11: OR; C cleared.
  - Z = (8-bit result == 0). Arithmetic wraps modulo 256.
- **LI (`01 rd[5:4] imm[3:0]`):** rd = zero-extended imm. Flags unchanged.
- **Jump (`10 cond[5:4] 00 off[1:0]`):**
  - cond 00 = always, 01 = Z, 10 = !Z, 11 = C; evaluated on current registered flags.
  - If taken: `JMP=1`, `JMP_OFFSET=off`, target = jump address + 2 + d'. Mapping off 00→A+2, 01→A+3, 10→A, 11→A+1.
  - Bits [3:2] are ignored.
- **Misc (`11 xxxxxx`):** 111111 = HALT; every other code is a NOP.
- **HALT when valid:** drive `JMP=1`, `JMP_OFFSET=10` so the counter returns to the HALT address; set `HALTED` at the same edge.
- **While `HALTED`:** `JMP=1`, `JMP_OFFSET=11` every cycle (counter holds), `IR_V=0`, no register or flag writes. Only `RST` clears `HALTED`.
- **Invalid IR (`IR_V=0`):** no writes, `JMP=0`.
- **Flush:** any taken jump or HALT squashes the instruction captured at the same edge (exactly one bubble).
- **State machine:** RUN → HALTED on a valid HALT; HALTED → RUN only on `RST`.

## Timing
- **Reset (asynchronous):** R0–R3=0, Z=0, C=0, `HALTED`=0, `IR_V`=0, IR=0x00, `IR_ADDR`=0; therefore `JMP`=0, `JMP_OFFSET`=00, `RD_DATA`=0. No external reset sync.
- **Latency:** instruction at address A is in IR one cycle after `ADDR`=A. Its result is visible on `RD_DATA` one cycle later.
- **Dependencies:** back-to-back dependent instructions need no stall, because write and flag update happen before the next IR cycle.
- **Jump outputs:** `JMP`/`JMP_OFFSET` are combinational from IR, `IR_V`, flags and `HALTED`, and must settle within the same cycle.
- **Reset mid-operation:** behaves exactly like reset at power-up, including the HALTED state and a pending flush. The first valid IR after release is instr[0].

## Test plan
- **Conditional skip:** program 0x45, 0x55, 0x05, 0x90, 0x61, 0xFF → R0=0x00, Z=1, C=0, R2 stays 0x00. `ADDR` sequence is 0,1,2,3,4,5,6,5,5,5…, and `HALTED`=1 from the edge after HALT executes.
- **Flush:** program 0x81, 0x5F, 0x6F, 0x7F, 0xFF → `ADDR` 0,1,3,4,5…. R1=0x00 (squashed), R2=0x00 (never fetched), R3=0x0F.
- **Carry:** LI R0,F (0x4F), then five ADD R0,R0 (0x00) → R0 = 0x1E, 0x3C, 0x78, 0xF0, 0xE0. C=0 until the fifth add, then C=1. A following 0xB0 is taken.
- **Borrow:** LI R0,2 / LI R1,5 / SUB R0,R1 → R0=0xFD, C=1, Z=0. A following JNZ (0xA0) is taken.
- **Halt hold:** after HALT, hold for 20 cycles → `JMP`=1 and `JMP_OFFSET`=11 every cycle, `ADDR` constant, no register changes.
- **Reset mid-run:** assert `RST` asynchronously while halted and also mid-jump → all outputs hit their reset values immediately. After release, execution restarts from instr[0] with `IR_V`=0 on the first cycle.
